// File: rtl/distributor_32.sv
// distributor_32 : 1-to-2 buffered word distributor.
//
// A single valid/ready word stream is steered, one word at a time, into one of
// two small FIFOs. in_sel=0 selects output A and in_sel=1 selects output B.
// Each output drains independently through its own valid/ready handshake, so
// a stalled consumer only back-pressures words that are headed for it.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   flush                 synchronous clear of both FIFOs; blocks intake
//   in_valid/in_ready     producer handshake
//   in_data, in_sel       word and its destination (0 -> A, 1 -> B)
//   a_valid/a_ready/a_data   consumer A (a_data reads 0 when A is empty)
//   b_valid/b_ready/b_data   consumer B (b_data reads 0 when B is empty)
//   a_count, b_count      words accepted per destination since reset; these
//                         wrap, and neither flush nor pops affect them
//
// Lane 0 is A and lane 1 is B. Both lanes share one FIFO sub-module.

module distributor_32_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,     // already qualified with !full && !flush
    input  logic [WIDTH-1:0] din,
    input  logic             pop_rdy,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0]  PONE  = PW'(1);
    localparam logic [PW:0]    OONE  = (PW+1)'(1);
    localparam logic [PW:0]    OFULL = (PW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [PW:0]      occ;
    logic             pop;

    assign valid = (occ != '0);
    assign full  = (occ == OFULL);
    // A pop during flush is discarded together with the rest of the contents.
    assign pop   = valid && pop_rdy && !flush;
    assign dout  = valid ? mem[rp] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            occ   <= '0;
            count <= '0;
        end else begin
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                occ <= '0;
            end else begin
                if (push) wp <= wp + PONE;
                if (pop)  rp <= rp + PONE;
                case ({push, pop})
                    2'b10:   occ <= occ + OONE;
                    2'b01:   occ <= occ - OONE;
                    default: occ <= occ;
                endcase
            end
            // push is never asserted during flush, so flush cannot count.
            if (push) count <= count + CONE;
        end
    end

    // Storage needs no reset: occ gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
endmodule

module distributor_32 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]            full, push, rdy, vld;
    logic [NUM_LANES-1:0][WIDTH-1:0] dout;
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt;

    // Uses the full flag from before the edge, so a full FIFO popping this
    // cycle still refuses: there is no pass-through path.
    assign in_ready = !flush && !rst && !full[in_sel];
    assign push[0]  = in_valid && in_ready && !in_sel;
    assign push[1]  = in_valid && in_ready &&  in_sel;
    assign rdy      = {b_ready, a_ready};

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            distributor_32_fifo #(
                .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
            ) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .push   (push[i]),
                .din    (in_data),
                .pop_rdy(rdy[i]),
                .valid  (vld[i]),
                .dout   (dout[i]),
                .full   (full[i]),
                .count  (cnt[i])
            );
        end
    endgenerate

    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign a_data  = dout[0];
    assign b_data  = dout[1];
    assign a_count = cnt[0];
    assign b_count = cnt[1];
endmodule
